sao_stat_accu_mc: RTL and testbench
===================================

# sao_stat_accu_mc

Multi-category SAO statistics accumulator: takes NUM_PIX pixels per beat, each with a clipped signed difference (original − deblocked) and a category code. It accumulates a per-category difference sum and pixel count over one CTU. After the CTU's last beat it drains the NUM_CAT (sum, count) pairs through a valid/ready port and clears itself. It sits between the SAO classification stage and the offset/RD-decision stage, and generalises the single-category block to N categories, a parametrised pixel count, and handshaked I/O.

## Interface
- NUM_PIX, 4: pixels per input beat (≥1).
- NUM_CAT, 4: number of accumulated categories; valid codes 1..NUM_CAT.
- CAT_W, 3: category code width.
- DIFF_W, 5: signed diff width (diff_clip_bit+1).
- CNT_W, 12: per-category count width.
- SUM_W, DIFF_W+CNT_W: signed per-category sum width.
- CNT_TH, 2^CNT_W−NUM_PIX: count freeze threshold.
- clk  in  1  clock.
- arst_n  in  1  reset, asynchronous, active-low.
- srst_n  in  1  synchronous clear, active-low; same effect as arst_n.
- in_valid  in  1  beat valid.
- in_ready  out  1  block accepts beat.
- in_last  in  1  last beat of CTU.
- in_diff  in  NUM_PIX×DIFF_W  signed diffs, pixel i at [i*DIFF_W +: DIFF_W].
- in_cat  in  NUM_PIX×CAT_W  category per pixel; 0 or >NUM_CAT = not counted.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_cat  out  CAT_W  category of current result (1..NUM_CAT).
- out_sum  out  SUM_W  signed sum for out_cat.
- out_cnt  out  CNT_W  count for out_cat.
- out_last  out  1  high with category NUM_CAT.

## Operation
- States: ACCU, WAIT, DRAIN. The block resets to ACCU.
- ACCU: in_ready=1. A beat is accepted on in_valid&in_ready. If in_last is set on the accepted beat, go to WAIT.
- WAIT: in_ready=0. Hold for 2 cycles while the pipeline empties, then go to DRAIN with out_cat=1.
- DRAIN: in_ready=0 and out_valid=1. Each out_valid&out_ready handshake advances out_cat by 1. The handshake with out_last=1 zeroes all accumulators and returns to ACCU.
- Pipeline:
  - S1 registers diff/cat of the accepted beat plus a valid bit.
  - S2 computes, per category c, psum_c = Σ diff_i over pixels with cat_i==c (sign-extended), and pcnt_c = number of such pixels (width clog2(NUM_PIX+1)). Both are registered.
  - S3 accumulates: for each c, if S2 is valid and cnt_c < CNT_TH, then sum_c += psum_c and cnt_c += pcnt_c. Otherwise category c is frozen (sum and count unchanged). Categories freeze independently.
- Sums cannot overflow: the maximum count (< 2^CNT_W) times |diff| ≤ 2^(DIFF_W−1) fits in SUM_W.
- Outputs out_sum/out_cnt are muxed from the accumulator of out_cat. They are stable while out_valid&!out_ready.
- A beat with all categories invalid still occupies the pipeline. It updates nothing, but its in_last still triggers the drain.

## Timing
- Reset (arst_n or srst_n): state ACCU; in_ready=1; out_valid=0; out_cat=1; out_sum=0; out_cnt=0; out_last=0; all accumulators and pipeline valid bits are 0.
- A beat accepted in cycle t is reflected in the accumulators after the edge ending cycle t+2.
- Last beat accepted in cycle t:
  - in_ready=0 from t+1.
  - out_valid=1 from t+3 with out_cat=1.
- With out_ready held high, the drain takes NUM_CAT cycles.
- in_ready returns to 1 in the cycle after the out_last handshake.
- srst_n low mid-drain or mid-accumulation: aborts everything. Outputs take their reset values on the next cycle, and no partial results are emitted.
- in_valid=0 gaps are allowed anywhere inside a CTU; they add no latency beyond the gap itself.
- Input signals are ignored while in_ready=0.

## Test plan
- Two-beat CTU:
  - Stimulus: beat0 diff {3,−2,5,1}, cat {1,1,2,0}; beat1 (last) diff {−4,0,7,7}, cat {4,4,2,5}.
  - Required drain: (1, sum 1, cnt 2), (2, 12, 2), (3, 0, 0), (4, −4, 2, out_last=1).
- Saturation: 1024 beats, all pixels cat 1, diff −16, last on beat 1024 -> cat 1 drains sum −65472, cnt 4092 (frozen). Categories 2..4 drain 0/0.
- Latency: single last beat accepted in cycle t -> out_valid rises exactly at t+3, and in_ready is low for t+1..end of drain.
- Backpressure: out_ready low for 5 cycles during DRAIN on cat 2 -> out_cat/out_sum/out_cnt are constant. Release -> cats 2, 3, 4 follow on consecutive cycles, and in_ready=1 one cycle after the cat 4 handshake.
- srst_n pulse in the second drain cycle -> next cycle out_valid=0, in_ready=1. A new CTU with one beat of cat 3 diff 2 ×4 (last) drains cat 3 sum 8 cnt 4, with the other categories 0.
- Back-to-back CTUs with in_valid gaps of 0 to 3 cycles -> the second CTU's results contain no contribution from the first.

Source files
------------

// File: rtl/sao_stat_accu_mc.sv
// rtl/sao_stat_accu_mc.sv - multi-category SAO statistics accumulator
// Three-stage pipeline (register, per-category reduce, accumulate) with a drain FSM.
module sao_stat_accu_mc #(
  parameter int NUM_PIX = 4,
  parameter int NUM_CAT = 4,
  parameter int CAT_W   = 3,
  parameter int DIFF_W  = 5,
  parameter int CNT_W   = 12,
  parameter int SUM_W   = DIFF_W + CNT_W,
  parameter int CNT_TH  = 2**CNT_W - NUM_PIX
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      srst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      in_last_i,
  input  logic [NUM_PIX*DIFF_W-1:0] in_diff_i,
  input  logic [NUM_PIX*CAT_W-1:0]  in_cat_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [CAT_W-1:0]          out_cat_o,
  output logic signed [SUM_W-1:0]   out_sum_o,
  output logic [CNT_W-1:0]          out_cnt_o,
  output logic                      out_last_o
);
  localparam int PCNT_W = $clog2(NUM_PIX + 1);
  localparam int PSUM_W = DIFF_W + PCNT_W;
  localparam logic [CNT_W-1:0] CNT_TH_V = CNT_W'(CNT_TH);

  typedef enum logic [1:0] {ACCU, WAIT, DRAIN} state_t;

  state_t                    state_q;
  logic                      wait_q;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic                      out_last_q;
  logic [CAT_W-1:0]          out_cat_q;

  logic                      s1_vld_q;
  logic [NUM_PIX*DIFF_W-1:0] s1_diff_q;
  logic [NUM_PIX*CAT_W-1:0]  s1_cat_q;

  logic signed [DIFF_W-1:0]  pix_diff;
  logic signed [PSUM_W-1:0]  psum_d [NUM_CAT];
  logic [PCNT_W-1:0]         pcnt_d [NUM_CAT];
  logic                      s2_vld_q;
  logic signed [PSUM_W-1:0]  psum_q [NUM_CAT];
  logic [PCNT_W-1:0]         pcnt_q [NUM_CAT];

  logic signed [SUM_W-1:0]   acc_sum_q [NUM_CAT];
  logic [CNT_W-1:0]          acc_cnt_q [NUM_CAT];

  logic accept;
  logic clear;

  assign accept = in_valid_i & in_ready_q;
  assign clear  = out_valid_q & out_ready_i & out_last_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_vld_q  <= 1'b0;
      s1_diff_q <= '0;
      s1_cat_q  <= '0;
    end else if (!srst_n) begin
      s1_vld_q  <= 1'b0;
      s1_diff_q <= '0;
      s1_cat_q  <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_diff_q <= in_diff_i;
        s1_cat_q  <= in_cat_i;
      end
    end
  end

  // Codes 0 and >NUM_CAT match no category, so those pixels simply drop out.
  always_comb begin
    pix_diff = '0;
    for (int c = 0; c < NUM_CAT; c++) begin
      psum_d[c] = '0;
      pcnt_d[c] = '0;
    end
    for (int i = 0; i < NUM_PIX; i++) begin
      pix_diff = $signed(s1_diff_q[i*DIFF_W +: DIFF_W]);
      for (int c = 0; c < NUM_CAT; c++) begin
        if (s1_cat_q[i*CAT_W +: CAT_W] == CAT_W'(c + 1)) begin
          psum_d[c] = psum_d[c] + PSUM_W'(pix_diff);
          pcnt_d[c] = pcnt_d[c] + PCNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s2_vld_q <= 1'b0;
      for (int c = 0; c < NUM_CAT; c++) begin
        psum_q[c] <= '0;
        pcnt_q[c] <= '0;
      end
    end else if (!srst_n) begin
      s2_vld_q <= 1'b0;
      for (int c = 0; c < NUM_CAT; c++) begin
        psum_q[c] <= '0;
        pcnt_q[c] <= '0;
      end
    end else begin
      s2_vld_q <= s1_vld_q;
      for (int c = 0; c < NUM_CAT; c++) begin
        psum_q[c] <= psum_d[c];
        pcnt_q[c] <= pcnt_d[c];
      end
    end
  end

  // A category stops updating once its count reaches the threshold, keeping cnt below 2^CNT_W.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int c = 0; c < NUM_CAT; c++) begin
        acc_sum_q[c] <= '0;
        acc_cnt_q[c] <= '0;
      end
    end else if (!srst_n || clear) begin
      for (int c = 0; c < NUM_CAT; c++) begin
        acc_sum_q[c] <= '0;
        acc_cnt_q[c] <= '0;
      end
    end else if (s2_vld_q) begin
      for (int c = 0; c < NUM_CAT; c++) begin
        if (acc_cnt_q[c] < CNT_TH_V) begin
          acc_sum_q[c] <= acc_sum_q[c] + SUM_W'(psum_q[c]);
          acc_cnt_q[c] <= acc_cnt_q[c] + CNT_W'(pcnt_q[c]);
        end
      end
    end
  end

  // WAIT covers the two cycles the last beat needs to reach the accumulators.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ACCU;
      wait_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_cat_q   <= CAT_W'(1);
    end else if (!srst_n) begin
      state_q     <= ACCU;
      wait_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_cat_q   <= CAT_W'(1);
    end else begin
      case (state_q)
        ACCU: begin
          if (accept && in_last_i) begin
            state_q    <= WAIT;
            wait_q     <= 1'b0;
            in_ready_q <= 1'b0;
          end
        end
        WAIT: begin
          if (wait_q) begin
            state_q     <= DRAIN;
            out_valid_q <= 1'b1;
            out_cat_q   <= CAT_W'(1);
            out_last_q  <= (NUM_CAT == 1);
          end else begin
            wait_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready_i) begin
            if (out_last_q) begin
              state_q     <= ACCU;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_cat_q   <= CAT_W'(1);
            end else begin
              out_cat_q  <= out_cat_q + CAT_W'(1);
              out_last_q <= (out_cat_q + CAT_W'(1) == CAT_W'(NUM_CAT));
            end
          end
        end
        default: state_q <= ACCU;
      endcase
    end
  end

  always_comb begin
    out_sum_o = '0;
    out_cnt_o = '0;
    for (int c = 0; c < NUM_CAT; c++) begin
      if (out_cat_q == CAT_W'(c + 1)) begin
        out_sum_o = acc_sum_q[c];
        out_cnt_o = acc_cnt_q[c];
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_cat_o   = out_cat_q;

endmodule

// File: tb/tb_sao_stat_accu_mc.sv
// tb/tb_sao_stat_accu_mc.sv - self-checking bench for sao_stat_accu_mc
// Reference model: per-beat category sums/counts with threshold freeze, in plain integers.
module tb_sao_stat_accu_mc;
  localparam int NUM_PIX = 4;
  localparam int NUM_CAT = 4;
  localparam int CAT_W   = 3;
  localparam int DIFF_W  = 5;
  localparam int CNT_W   = 12;
  localparam int SUM_W   = 17;
  localparam int CNT_TH  = 4092;

  logic                      clk = 1'b0;
  logic                      arst_n = 1'b0;
  logic                      srst_n = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic                      in_last = 1'b0;
  logic [NUM_PIX*DIFF_W-1:0] in_diff = '0;
  logic [NUM_PIX*CAT_W-1:0]  in_cat = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [CAT_W-1:0]          out_cat;
  logic signed [SUM_W-1:0]   out_sum;
  logic [CNT_W-1:0]          out_cnt;
  logic                      out_last;

  int pass_cnt = 0;
  int total_cnt = 0;
  int bd [NUM_PIX];
  int bc [NUM_PIX];
  int m_sum [1:NUM_CAT];
  int m_cnt [1:NUM_CAT];

  sao_stat_accu_mc dut (
    .clk(clk), .arst_n(arst_n), .srst_n(srst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last),
    .in_diff_i(in_diff), .in_cat_i(in_cat),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_cat_o(out_cat),
    .out_sum_o(out_sum), .out_cnt_o(out_cnt), .out_last_o(out_last)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int c = 1; c <= NUM_CAT; c++) begin
      m_sum[c] = 0;
      m_cnt[c] = 0;
    end
  endtask

  task automatic rand_beat();
    for (int i = 0; i < NUM_PIX; i++) begin
      bd[i] = int'($urandom_range(0, 31)) - 16;
      bc[i] = int'($urandom_range(0, 7));
    end
  endtask

  task automatic drive_beat(input logic vld, input logic last);
    for (int i = 0; i < NUM_PIX; i++) begin
      in_diff[i*DIFF_W +: DIFF_W] = DIFF_W'(bd[i]);
      in_cat[i*CAT_W +: CAT_W]    = CAT_W'(bc[i]);
    end
    in_valid = vld;
    in_last  = last;
  endtask

  task automatic send_beat(input logic last);
    int n;
    int ps;
    int pc;
    drive_beat(1'b1, last);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL beat_ready got %b exp 1", in_ready);
    else pass_cnt++;
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int c = 1; c <= NUM_CAT; c++) begin
      ps = 0;
      pc = 0;
      for (int i = 0; i < NUM_PIX; i++) begin
        if (bc[i] == c) begin
          ps += bd[i];
          pc++;
        end
      end
      if (m_cnt[c] < CNT_TH) begin
        m_sum[c] += ps;
        m_cnt[c] += pc;
      end
    end
  endtask

  task automatic gap(input int n);
    for (int g = 0; g < n; g++) begin
      rand_beat();
      drive_beat(1'b0, 1'($urandom_range(0, 1)));
      cyc();
    end
    in_valid = 1'b0;
  endtask

  // Garbage is driven on the input port throughout the drain; it must be ignored.
  task automatic drain_check(input int stall_cat, input int stall_len);
    int n;
    rand_beat();
    drive_beat(1'b1, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    total_cnt++;
    if (out_valid !== 1'b1) begin
      $display("FAIL drain_timeout got %b exp 1", out_valid);
      in_valid = 1'b0;
      return;
    end
    pass_cnt++;
    for (int k = 1; k <= NUM_CAT; k++) begin
      if (k == stall_cat) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          total_cnt++;
          if (out_cat !== CAT_W'(k) || out_sum !== SUM_W'(m_sum[k]) || out_cnt !== CNT_W'(m_cnt[k]) || out_valid !== 1'b1)
            $display("FAIL stall_hold cat %0d got (%0d,%0d,%0d,v%b) exp (%0d,%0d,%0d,v1)",
                     k, out_cat, out_sum, out_cnt, out_valid, k, m_sum[k], m_cnt[k]);
          else pass_cnt++;
          cyc();
        end
      end
      out_ready = 1'b1;
      total_cnt++;
      if (out_valid !== 1'b1 || out_cat !== CAT_W'(k)) $display("FAIL drain_cat got v%b cat %0d exp v1 cat %0d", out_valid, out_cat, k);
      else pass_cnt++;
      total_cnt++;
      if (out_sum !== SUM_W'(m_sum[k])) $display("FAIL drain_sum cat %0d got %0d exp %0d", k, out_sum, m_sum[k]);
      else pass_cnt++;
      total_cnt++;
      if (out_cnt !== CNT_W'(m_cnt[k])) $display("FAIL drain_cnt cat %0d got %0d exp %0d", k, out_cnt, m_cnt[k]);
      else pass_cnt++;
      total_cnt++;
      if (out_last !== (k == NUM_CAT) || in_ready !== 1'b0)
        $display("FAIL drain_flags cat %0d got last %b ready %b exp last %b ready 0", k, out_last, in_ready, (k == NUM_CAT));
      else pass_cnt++;
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL drain_return got ready %b valid %b exp ready 1 valid 0", in_ready, out_valid);
    else pass_cnt++;
    model_clear();
  endtask

  task automatic test_reset();
    model_clear();
    cyc();
    cyc();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0)
      $display("FAIL reset_flags got ready %b valid %b last %b exp 1 0 0", in_ready, out_valid, out_last);
    else pass_cnt++;
    arst_n = 1'b1;
    cyc();
    total_cnt++;
    if (out_cat !== CAT_W'(1) || out_sum !== '0 || out_cnt !== '0)
      $display("FAIL reset_data got (%0d,%0d,%0d) exp (1,0,0)", out_cat, out_sum, out_cnt);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_release got ready %b valid %b exp 1 0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_two_beat();
    bd = '{3, -2, 5, 1};
    bc = '{1, 1, 2, 0};
    send_beat(1'b0);
    bd = '{-4, 0, 7, 7};
    bc = '{4, 4, 2, 5};
    send_beat(1'b1);
    total_cnt++;
    if (m_sum[1] != 1 || m_cnt[2] != 2 || m_sum[2] != 12 || m_sum[4] != -4)
      $display("FAIL two_beat_model got %0d %0d %0d exp 1 2 12 -4", m_sum[1], m_cnt[2], m_sum[2]);
    else pass_cnt++;
    drain_check(0, 0);
  endtask

  task automatic test_latency();
    int n;
    rand_beat();
    send_beat(1'b1);
    n = 1;
    while (out_valid !== 1'b1 && n < 10) begin
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL latency_ready cycle t+%0d got %b exp 0", n, in_ready);
      else pass_cnt++;
      cyc();
      n++;
    end
    total_cnt++;
    if (n != 3) $display("FAIL latency_valid got t+%0d exp t+3", n);
    else pass_cnt++;
    drain_check(0, 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < NUM_PIX; i++) begin
      bd[i] = -16;
      bc[i] = 1;
    end
    for (int b = 1; b <= 1024; b++) send_beat(b == 1024);
    total_cnt++;
    if (m_sum[1] != -65472 || m_cnt[1] != 4092) $display("FAIL sat_model got %0d %0d exp -65472 4092", m_sum[1], m_cnt[1]);
    else pass_cnt++;
    drain_check(0, 0);
  endtask

  task automatic test_backpressure();
    for (int b = 0; b < 3; b++) begin
      rand_beat();
      send_beat(b == 2);
    end
    drain_check(2, 5);
  endtask

  task automatic test_srst();
    int n;
    for (int b = 0; b < 2; b++) begin
      rand_beat();
      send_beat(b == 1);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    out_ready = 1'b1;
    cyc();
    srst_n = 1'b0;
    cyc();
    srst_n    = 1'b1;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0)
      $display("FAIL srst_flags got valid %b ready %b last %b exp 0 1 0", out_valid, in_ready, out_last);
    else pass_cnt++;
    total_cnt++;
    if (out_cat !== CAT_W'(1) || out_sum !== '0 || out_cnt !== '0)
      $display("FAIL srst_data got (%0d,%0d,%0d) exp (1,0,0)", out_cat, out_sum, out_cnt);
    else pass_cnt++;
    model_clear();
    for (int i = 0; i < NUM_PIX; i++) begin
      bd[i] = 2;
      bc[i] = 3;
    end
    send_beat(1'b1);
    total_cnt++;
    if (m_sum[3] != 8 || m_cnt[3] != 4 || m_cnt[1] != 0) $display("FAIL srst_model got %0d %0d exp 8 4", m_sum[3], m_cnt[3]);
    else pass_cnt++;
    drain_check(0, 0);
  endtask

  task automatic test_back_to_back();
    int nb;
    for (int t = 0; t < 6; t++) begin
      gap(t % 4);
      nb = int'($urandom_range(1, 6));
      for (int b = 0; b < nb; b++) begin
        rand_beat();
        send_beat(b == nb - 1);
        if (b != nb - 1) gap(int'($urandom_range(0, 3)));
      end
      drain_check((t % 2 == 0) ? int'($urandom_range(1, NUM_CAT)) : 0, int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_two_beat();
    test_latency();
    test_saturation();
    test_backpressure();
    test_srst();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
